// File: rtl/minmax_pkg.sv
// Shared definitions for the burst min/max sequencer: state encoding and
// default widths used by the top and the comparator.
package minmax_pkg;

    localparam int DEFAULT_DATA_W  = 16;
    localparam int DEFAULT_COUNT_W = 8;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LOAD    = 3'd1,
        S_FETCH   = 3'd2,
        S_CMP_MAX = 3'd3,
        S_CMP_MIN = 3'd4,
        S_DONE    = 3'd5
    } state_t;

endpackage

// File: rtl/mag_comparator.sv
// Unsigned magnitude comparator; exactly one of gt/lt/eq is high.
module mag_comparator #(
    parameter int DATA_W = 16
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic              gt,
    output logic              lt,
    output logic              eq
);

    assign gt = (a > b);
    assign lt = (a < b);
    assign eq = (a == b);

endmodule

// File: rtl/minmax_seq.sv
// Burst min/max sequencer: accepts samples over valid/ready and tracks the
// running extremes through one shared comparator, one compare per cycle.
module minmax_seq
    import minmax_pkg::*;
#(
    parameter int DATA_W  = DEFAULT_DATA_W,
    parameter int COUNT_W = DEFAULT_COUNT_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [COUNT_W-1:0] burst_len,
    input  logic [DATA_W-1:0]  in_data,
    input  logic               in_valid,
    output logic               in_ready,
    output logic [DATA_W-1:0]  max_out,
    output logic [DATA_W-1:0]  min_out,
    output logic               busy,
    output logic               done
);

    state_t             state;
    state_t             state_next;
    logic [COUNT_W-1:0] cnt;
    logic [COUNT_W-1:0] cnt_inc;
    logic [COUNT_W-1:0] len_reg;
    logic [DATA_W-1:0]  sample_reg;
    logic [DATA_W-1:0]  cmp_b;
    logic               cmp_gt;
    logic               cmp_lt;
    logic               cmp_eq;
    logic               xfer;

    assign xfer    = in_valid & in_ready;
    assign cnt_inc = cnt + 1'b1;

    // The comparator's b side is always the extreme register being updated.
    assign cmp_b = (state == S_CMP_MIN) ? min_out : max_out;

    mag_comparator #(.DATA_W(DATA_W)) u_cmp (
        .a  (sample_reg),
        .b  (cmp_b),
        .gt (cmp_gt),
        .lt (cmp_lt),
        .eq (cmp_eq)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        busy       = 1'b1;
        done       = 1'b0;
        unique case (state)
            S_IDLE: begin
                busy = 1'b0;
                if (start && (burst_len != '0)) state_next = S_LOAD;
            end
            S_LOAD: begin
                in_ready = 1'b1;
                if (in_valid) state_next = (len_reg == COUNT_W'(1)) ? S_DONE : S_FETCH;
            end
            S_FETCH: begin
                in_ready = 1'b1;
                if (in_valid) state_next = S_CMP_MAX;
            end
            S_CMP_MAX: state_next = S_CMP_MIN;
            S_CMP_MIN: state_next = (cnt_inc == len_reg) ? S_DONE : S_FETCH;
            S_DONE: begin
                done       = 1'b1;
                state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Ties leave the register alone so the earlier sample is retained.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt        <= '0;
            len_reg    <= '0;
            sample_reg <= '0;
            max_out    <= '0;
            min_out    <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start && (burst_len != '0)) len_reg <= burst_len;
                end
                S_LOAD: begin
                    if (xfer) begin
                        max_out <= in_data;
                        min_out <= in_data;
                        cnt     <= COUNT_W'(1);
                    end
                end
                S_FETCH: begin
                    if (xfer) sample_reg <= in_data;
                end
                S_CMP_MAX: begin
                    if (cmp_gt) max_out <= sample_reg;
                end
                S_CMP_MIN: begin
                    if (cmp_lt && !cmp_eq) min_out <= sample_reg;
                    cnt <= cnt_inc;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_minmax_seq.sv
// Randomized self-checking bench for minmax_seq; expected extremes, handshake
// timing and done latency come from a plain behavioural model of a burst.
module tb_minmax_seq;

    localparam int DW = 16;
    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [CW-1:0] burst_len;
    logic [DW-1:0] in_data;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] max_out;
    logic [DW-1:0] min_out;
    logic          busy;
    logic          done;

    int checks = 0;
    int errors = 0;
    logic [DW-1:0] samples[$];

    always #5 clk = ~clk;

    minmax_seq #(.DATA_W(DW), .COUNT_W(CW)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .burst_len (burst_len),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .max_out   (max_out),
        .min_out   (min_out),
        .busy      (busy),
        .done      (done)
    );

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Sample i is accepted immediately for the first two; afterwards the block
    // needs three cycles per sample before it is ready again.
    function automatic logic expReady(input int i, input int since);
        if (i <= 1) return 1'b1;
        return (since >= 3);
    endfunction

    task automatic applyReset(input int cycles);
        rst      = 1'b1;
        start    = 1'b0;
        in_valid = 1'b0;
        repeat (cycles) step();
        rst = 1'b0;
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_done", done, 0);
        checkOutput("rst_ready", in_ready, 0);
        checkOutput("rst_max", max_out, 0);
        checkOutput("rst_min", min_out, 0);
    endtask

    task automatic fillRandom(input int len);
        logic [DW-1:0] corner[4];
        corner[0] = 16'h0000;
        corner[1] = 16'h0001;
        corner[2] = 16'hFFFF;
        corner[3] = 16'h8000;
        samples.delete();
        for (int k = 0; k < len; k++) begin
            if ($urandom_range(0, 3) == 0) samples.push_back(corner[$urandom_range(0, 3)]);
            else samples.push_back(DW'($urandom));
        end
    endtask

    // Runs one burst from the samples queue; abort_at>=0 stops after that many transfers.
    task automatic applyStimulus(input int len, input int max_gap, input bit poke_start, input int abort_at);
        logic [DW-1:0] exp_max;
        logic [DW-1:0] exp_min;
        int since;
        int waited;
        int gap;
        exp_max = samples[0];
        exp_min = samples[0];
        foreach (samples[k]) begin
            if (samples[k] > exp_max) exp_max = samples[k];
            if (samples[k] < exp_min) exp_min = samples[k];
        end
        start     = 1'b1;
        burst_len = CW'(len);
        step();
        start     = 1'b0;
        burst_len = CW'($urandom);
        checkOutput("busy_after_start", busy, 1);
        since = 0;
        for (int i = 0; i < len; i++) begin
            gap = (max_gap == 0) ? 0 : $urandom_range(0, max_gap);
            in_valid = 1'b0;
            for (int g = 0; g < gap; g++) begin
                checkOutput("ready_gap", in_ready, expReady(i, since));
                start = poke_start && (i > 0);
                step();
                since++;
            end
            in_valid = 1'b1;
            in_data  = samples[i];
            start    = poke_start && (i > 0);
            waited   = 0;
            while (!in_ready && waited < 20) begin
                checkOutput("ready_wait", in_ready, expReady(i, since));
                step();
                since++;
                waited++;
            end
            if (!in_ready) begin
                checkOutput("ready_timeout", in_ready, 1);
                in_valid = 1'b0;
                start    = 1'b0;
                return;
            end
            checkOutput("ready_at_xfer", in_ready, expReady(i, since));
            if (gap == 0 && i > 0) checkOutput("xfer_spacing", since, (i == 1) ? 1 : 3);
            step();
            in_valid = 1'b0;
            start    = 1'b0;
            since    = 1;
            if (abort_at >= 0 && i + 1 == abort_at) return;
        end
        while (!done && since < 20) begin
            checkOutput("ready_after_last", in_ready, 0);
            step();
            since++;
        end
        checkOutput("done_latency", since, (len == 1) ? 1 : 3);
        checkOutput("max_at_done", max_out, exp_max);
        checkOutput("min_at_done", min_out, exp_min);
        checkOutput("busy_at_done", busy, 1);
        step();
        checkOutput("done_pulse", done, 0);
        checkOutput("busy_after_done", busy, 0);
        checkOutput("max_hold", max_out, exp_max);
        checkOutput("min_hold", min_out, exp_min);
    endtask

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        burst_len = '0;
        in_data   = '0;
        in_valid  = 1'b0;
        applyReset(2);

        samples = '{16'h0010, 16'hFFFF, 16'h0000, 16'h0800};
        applyStimulus(4, 0, 1'b0, -1);

        samples = '{16'h1234};
        applyStimulus(1, 0, 1'b0, -1);

        start     = 1'b1;
        burst_len = '0;
        step();
        start = 1'b0;
        checkOutput("len0_busy", busy, 0);
        checkOutput("len0_ready", in_ready, 0);
        step();
        checkOutput("len0_busy_later", busy, 0);

        samples = '{16'h5555, 16'h5555, 16'h5555};
        applyStimulus(3, 0, 1'b0, -1);
        samples = '{16'h8000, 16'h7FFF};
        applyStimulus(2, 0, 1'b0, -1);

        fillRandom(3);
        applyStimulus(3, 5, 1'b1, -1);

        samples = '{16'h0100, 16'h0200, 16'h0300, 16'h0400};
        applyStimulus(4, 0, 1'b0, 2);
        applyReset(2);
        samples = '{16'h0003, 16'h0001};
        applyStimulus(2, 0, 1'b0, -1);

        for (int n = 0; n < 30; n++) begin
            int len;
            len = $urandom_range(1, 10);
            fillRandom(len);
            applyStimulus(len, ($urandom_range(0, 1) == 1) ? 4 : 0, 1'(($urandom_range(0, 1))), -1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
